// File: rtl/half_duplex_link.sv
// Far-side agent on a shared single-wire line: transmits when dir=0, receives when dir=1,
// with turnaround cycles on every direction change and retransmission of interrupted frames.
module half_duplex_link #(
  parameter int W           = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         dir,
  inout  wire          line,
  input  logic [W-1:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  output logic         tx_done,
  output logic         tx_abort,
  output logic [W-1:0] rx_data,
  output logic         rx_valid,
  output logic         rx_err
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [2:0] {
    TURN     = 3'd0,
    IDLE_TX  = 3'd1,
    TX_SHIFT = 3'd2,
    IDLE_RX  = 3'd3,
    RX_SHIFT = 3'd4
  } state_t;

  state_t          state_q;
  logic            dir_q;
  logic [3:0]      turn_cnt_q;
  logic [CW-1:0]   bit_cnt_q;
  logic            pending_q;
  logic            drv_q;
  logic [W-1:0]    shift_q;
  logic [W-1:0]    held_q;
  logic [W-1:0]    rx_shift_q;
  logic [W-1:0]    rx_data_q;
  logic            tx_done_q;
  logic            tx_abort_q;
  logic            rx_valid_q;
  logic            rx_err_q;

  logic            line_s;
  logic [4:0]      turn_inc_s;

  assign line_s     = line;
  assign turn_inc_s = {1'b0, turn_cnt_q} + 5'd1;

  // The !dir term releases the line in the same cycle the peer takes ownership.
  assign line     = (state_q == TX_SHIFT && !dir) ? drv_q : 1'bz;
  assign tx_ready = (state_q == IDLE_TX) && !dir && !pending_q;

  assign tx_done  = tx_done_q;
  assign tx_abort = tx_abort_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;

  // Link FSM with turnaround counting, TX serialiser, RX deserialiser and pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TURN;
      dir_q      <= 1'b1;
      turn_cnt_q <= 4'd0;
      bit_cnt_q  <= '0;
      pending_q  <= 1'b0;
      drv_q      <= 1'b0;
      shift_q    <= '0;
      held_q     <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      tx_done_q  <= 1'b0;
      tx_abort_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      dir_q      <= dir;
      tx_done_q  <= 1'b0;
      tx_abort_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      case (state_q)
        TURN: begin
          if (dir != dir_q) begin
            turn_cnt_q <= 4'd0;
          end else if (turn_inc_s >= 5'(TURN_CYCLES)) begin
            turn_cnt_q <= 4'd0;
            state_q    <= dir ? IDLE_RX : IDLE_TX;
          end else begin
            turn_cnt_q <= turn_inc_s[3:0];
          end
        end
        IDLE_TX: begin
          if (dir) begin
            state_q    <= TURN;
            turn_cnt_q <= 4'd0;
          end else if (pending_q) begin
            shift_q   <= held_q;
            drv_q     <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= TX_SHIFT;
          end else if (tx_valid) begin
            shift_q   <= tx_data;
            held_q    <= tx_data;
            pending_q <= 1'b1;
            drv_q     <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= TX_SHIFT;
          end else begin
            drv_q <= 1'b0;
          end
        end
        TX_SHIFT: begin
          if (dir) begin
            state_q    <= TURN;
            turn_cnt_q <= 4'd0;
            tx_abort_q <= 1'b1;
            shift_q    <= held_q;
            drv_q      <= 1'b0;
          end else if (bit_cnt_q == CW'(W)) begin
            state_q   <= IDLE_TX;
            pending_q <= 1'b0;
            tx_done_q <= 1'b1;
            drv_q     <= 1'b0;
          end else begin
            drv_q     <= shift_q[W-1];
            shift_q   <= {shift_q[W-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + CW'(1);
          end
        end
        IDLE_RX: begin
          if (!dir) begin
            state_q    <= TURN;
            turn_cnt_q <= 4'd0;
          end else if (line_s) begin
            state_q   <= RX_SHIFT;
            bit_cnt_q <= '0;
          end else begin
            bit_cnt_q <= '0;
          end
        end
        RX_SHIFT: begin
          if (!dir) begin
            state_q    <= TURN;
            turn_cnt_q <= 4'd0;
            rx_err_q   <= 1'b1;
          end else begin
            rx_shift_q <= {rx_shift_q[W-2:0], line_s};
            if (bit_cnt_q == CW'(W - 1)) begin
              rx_data_q  <= {rx_shift_q[W-2:0], line_s};
              rx_valid_q <= 1'b1;
              state_q    <= IDLE_RX;
            end else begin
              bit_cnt_q <= bit_cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q    <= TURN;
          turn_cnt_q <= 4'd0;
          drv_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_half_duplex_link.sv
// Directed bench for half_duplex_link: TX framing, RX, turnaround, abort/retransmit, reset.
module tb_half_duplex_link;

  localparam int W = 8;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b1;
  logic         dir      = 1'b0;
  logic [W-1:0] tx_data  = '0;
  logic         tx_valid = 1'b0;
  logic         peer_en  = 1'b0;
  logic         peer_bit = 1'b0;
  wire          line;
  logic         tx_ready, tx_done, tx_abort, rx_valid, rx_err;
  logic [W-1:0] rx_data;

  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] d;
  logic [3:0]   alt_exp;

  assign line = peer_en ? peer_bit : 1'bz;
  pulldown (line);

  always #5 clk = ~clk;

  half_duplex_link #(.W(W), .TURN_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .dir(dir), .line(line),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_abort(tx_abort),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_tx_abort", tx_abort, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_err", rx_err, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_line", line, 0);
    tick; tick;
    rst_n = 1'b1;

    // Turnaround from reset, then send A5
    tick;
    chk("turn_ready", tx_ready, 0);
    tick;
    chk("idle_ready", tx_ready, 1);
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick;
    tx_valid = 1'b0;
    chk("a5_start", line, 1);
    chk("a5_busy_ready", tx_ready, 0);
    d = 8'hA5;
    for (int i = W - 1; i >= 0; i--) begin
      tick;
      chk("a5_bit", line, d[i]);
      chk("a5_no_done", tx_done, 0);
    end
    tick;
    chk("a5_done", tx_done, 1);
    chk("a5_release", line, 0);
    chk("a5_ready_again", tx_ready, 1);
    tick;
    chk("a5_done_pulse", tx_done, 0);

    // Receive 3C from the peer
    dir = 1'b1;
    #1;
    chk("dir1_ready_comb", tx_ready, 0);
    tick; tick;
    peer_en = 1'b1; peer_bit = 1'b1;
    tick;
    d = 8'h3C;
    for (int i = W - 1; i >= 0; i--) begin
      peer_bit = d[i];
      tick;
      chk("rx_line_peer", line, d[i]);
      if (i > 0) chk("rx_no_valid", rx_valid, 0);
    end
    chk("rx_valid", rx_valid, 1);
    chk("rx_data", rx_data, 8'h3C);
    peer_en = 1'b0;
    tick;
    chk("rx_valid_pulse", rx_valid, 0);
    chk("rx_data_hold", rx_data, 8'h3C);

    // Direction falls mid RX frame
    peer_en = 1'b1; peer_bit = 1'b1;
    tick;
    peer_bit = 1'b1; tick;
    peer_bit = 1'b0; tick;
    peer_bit = 1'b1; tick;
    dir = 1'b0; peer_en = 1'b0;
    tick;
    chk("rxerr_pulse", rx_err, 1);
    chk("rxerr_no_valid", rx_valid, 0);
    chk("rxerr_data_kept", rx_data, 8'h3C);
    tick;
    chk("rxerr_clear", rx_err, 0);
    chk("rxerr_ready", tx_ready, 1);

    // Abort F0 after three data bits, then retransmit
    tx_data = 8'hF0; tx_valid = 1'b1;
    tick;
    tx_valid = 1'b0;
    chk("f0_start", line, 1);
    tick; tick; tick;
    chk("f0_pre_abort", line, 1);
    dir = 1'b1;
    #1;
    chk("f0_release_same_cycle", line, 0);
    tick;
    chk("f0_abort", tx_abort, 1);
    chk("f0_no_done", tx_done, 0);
    tick;
    chk("f0_abort_pulse", tx_abort, 0);
    dir = 1'b0;
    tick;
    chk("f0_turn_line", line, 0);
    tick;
    chk("f0_pending_ready", tx_ready, 0);
    chk("f0_turn_line2", line, 0);
    tick;
    chk("f0_re_start", line, 1);
    d = 8'hF0;
    for (int i = W - 1; i >= 0; i--) begin
      tick;
      chk("f0_re_bit", line, d[i]);
    end
    tick;
    chk("f0_re_done", tx_done, 1);

    // Alternate dir every 4 cycles with FF offered
    tx_data = 8'hFF; tx_valid = 1'b1;
    alt_exp = 4'b1100;
    for (int r = 0; r < 3; r++) begin
      dir = 1'b1;
      #1;
      chk("alt_rise_release", line, 0);
      for (int k = 0; k < 4; k++) begin
        tick;
        chk("alt_dir1_line", line, 0);
        if (k == 0 && r > 0) chk("alt_abort", tx_abort, 1);
      end
      dir = 1'b0;
      #1;
      chk("alt_fall_line", line, 0);
      for (int k = 0; k < 4; k++) begin
        tick;
        chk("alt_dir0_line", line, alt_exp[k]);
      end
    end

    // Reset mid TX: immediate release, no retransmit afterwards
    tx_valid = 1'b0;
    tick;
    chk("rst_pre_line", line, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_line", line, 0);
    chk("rst_mid_ready", tx_ready, 0);
    chk("rst_mid_abort", tx_abort, 0);
    chk("rst_mid_done", tx_done, 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("rst_post_abort", tx_abort, 0);
    chk("rst_post_done", tx_done, 0);
    tick;
    chk("rst_no_pending", tx_ready, 1);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("rst_no_retx", line, 0);
    end
    tx_data = 8'h81; tx_valid = 1'b1;
    tick;
    tx_valid = 1'b0;
    chk("x81_start", line, 1);
    d = 8'h81;
    for (int i = W - 1; i >= 0; i--) begin
      tick;
      chk("x81_bit", line, d[i]);
    end
    tick;
    chk("x81_done", tx_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
